// File: rtl/freeze_judge.sv
// freeze_judge: freeze mini-game engine. Samples mic_in, tracks per-window
// peak, runs ARM then FREEZE countdown and reports win/lose on res.
// Ports: basys_clock, rst_n (async low), mic_in[11:0], start (level),
//   res[1:0] 0 play/idle 1 win 2 lose, secs_left[3:0], phase[1:0],
//   peak[11:0] last window peak, lives[1:0].
// Optional: define FREEZE_LIVES_EN for three lives per round.
module freeze_judge #(
  parameter int          CLK_HZ       = 100000000,
  parameter int          SAMPLE_HZ    = 20000,
  parameter int          WINDOW       = 2000,
  parameter logic [11:0] QUIET_THRESH = 12'd2300,
  parameter int          ARM_S        = 3,
  parameter int          COUNT_S      = 9
) (
  input  logic        basys_clock,
  input  logic        rst_n,
  input  logic [11:0] mic_in,
  input  logic        start,
  output logic [1:0]  res,
  output logic [3:0]  secs_left,
  output logic [1:0]  phase,
  output logic [11:0] peak,
  output logic [1:0]  lives
);

  localparam int SDIV = CLK_HZ / SAMPLE_HZ;
  localparam int SW   = $clog2(SDIV + 1);
  localparam int CW   = $clog2(CLK_HZ + 1);
  localparam int WW   = $clog2(WINDOW + 1);

`ifdef FREEZE_LIVES_EN
  localparam logic [1:0] LIVES_INIT = 2'd3;
`else
  localparam logic [1:0] LIVES_INIT = 2'd1;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    FREEZE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_d;

  logic [SW-1:0] samp_div;
  logic [CW-1:0] sec_div;
  logic [WW-1:0] samp_cnt;
  logic [11:0]   cur_max;
  logic [11:0]   samp_max;
  logic          samp_tick;
  logic          sec_tick;
  logic          start_q;
  logic          start_edge;
  logic          win_done;
  logic          freeze_entry;
  logic          loud;
  logic [1:0]    res_d;
  logic [3:0]    secs_d;
  logic [1:0]    lives_d;

  assign samp_tick  = (samp_div == SW'(SDIV - 1));
  assign sec_tick   = (sec_div == CW'(CLK_HZ - 1));
  assign start_edge = start & ~start_q;
  assign samp_max   = (mic_in > cur_max) ? mic_in : cur_max;
  assign loud       = win_done && (peak > QUIET_THRESH);
  assign phase      = state;

  always_ff @(posedge basys_clock or negedge rst_n) begin
    if (!rst_n) begin
      samp_div <= '0;
      sec_div  <= '0;
      start_q  <= 1'b0;
    end else begin
      start_q <= start;
      if (samp_tick) samp_div <= '0;
      else           samp_div <= samp_div + SW'(1);
      // A new round realigns the seconds grid to the start press.
      if (start_edge || sec_tick) sec_div <= '0;
      else                        sec_div <= sec_div + CW'(1);
    end
  end

  always_ff @(posedge basys_clock or negedge rst_n) begin
    if (!rst_n) begin
      cur_max  <= '0;
      samp_cnt <= '0;
      peak     <= '0;
      win_done <= 1'b0;
    end else begin
      win_done <= 1'b0;
      // Judging starts on a fresh window so ARM noise never leaks in.
      if (start_edge || freeze_entry) begin
        cur_max  <= '0;
        samp_cnt <= '0;
      end else if (samp_tick) begin
        if (samp_cnt == WW'(WINDOW - 1)) begin
          peak     <= samp_max;
          cur_max  <= '0;
          samp_cnt <= '0;
          win_done <= 1'b1;
        end else begin
          cur_max  <= samp_max;
          samp_cnt <= samp_cnt + WW'(1);
        end
      end
    end
  end

  always_ff @(posedge basys_clock or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      res       <= 2'd0;
      secs_left <= 4'd0;
      lives     <= 2'd1;
    end else begin
      state     <= state_d;
      res       <= res_d;
      secs_left <= secs_d;
      lives     <= lives_d;
    end
  end

  always_comb begin
    state_d      = state;
    res_d        = res;
    secs_d       = secs_left;
    lives_d      = lives;
    freeze_entry = 1'b0;
    if (start_edge) begin
      state_d = ARM;
      res_d   = 2'd0;
      secs_d  = 4'(ARM_S);
      lives_d = LIVES_INIT;
    end else begin
      unique case (state)
        IDLE: begin
          res_d  = 2'd0;
          secs_d = 4'd0;
        end
        ARM: begin
          if (sec_tick) begin
            if (secs_left == 4'd1) begin
              state_d      = FREEZE;
              secs_d       = 4'(COUNT_S);
              freeze_entry = 1'b1;
            end else begin
              secs_d = secs_left - 4'd1;
            end
          end
        end
        FREEZE: begin
`ifdef FREEZE_LIVES_EN
          if (loud && lives == 2'd1) begin
            state_d = DONE;
            res_d   = 2'd2;
            lives_d = 2'd0;
          end else begin
            if (loud) lives_d = lives - 2'd1;
            if (sec_tick) begin
              if (secs_left == 4'd1) begin
                state_d = DONE;
                res_d   = 2'd1;
                secs_d  = 4'd0;
              end else begin
                secs_d = secs_left - 4'd1;
              end
            end
          end
`else
          // Loud beats the final second when both land together.
          if (loud) begin
            state_d = DONE;
            res_d   = 2'd2;
          end else if (sec_tick) begin
            if (secs_left == 4'd1) begin
              state_d = DONE;
              res_d   = 2'd1;
              secs_d  = 4'd0;
            end else begin
              secs_d = secs_left - 4'd1;
            end
          end
`endif
        end
        DONE: begin
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freeze_judge.sv
// tb_freeze_judge: scoreboard bench for freeze_judge at reduced rates.
// Output events on {phase,res,lives} are matched against queued expectations.
module tb_freeze_judge;

`ifdef FREEZE_LIVES_EN
  localparam logic [1:0] LV = 2'd3;
`else
  localparam logic [1:0] LV = 2'd1;
`endif

  typedef struct {
    int          cyc;
    bit          chk_cyc;
    logic [1:0]  ph;
    logic [1:0]  res;
    logic [3:0]  secs;
    bit          chk_peak;
    logic [11:0] peak;
    logic [1:0]  lives;
  } ev_t;

  logic        clk;
  logic        rst_n;
  logic [11:0] mic_in;
  logic        start;
  logic [1:0]  res;
  logic [3:0]  secs_left;
  logic [1:0]  phase;
  logic [11:0] peak;
  logic [1:0]  lives;

  int  cyc;
  int  checks;
  int  failures;
  int  nev;
  ev_t sb[$];

  freeze_judge #(
    .CLK_HZ(1000),
    .SAMPLE_HZ(100),
    .WINDOW(10),
    .QUIET_THRESH(12'd2300),
    .ARM_S(1),
    .COUNT_S(3)
  ) dut (
    .basys_clock(clk),
    .rst_n(rst_n),
    .mic_in(mic_in),
    .start(start),
    .res(res),
    .secs_left(secs_left),
    .phase(phase),
    .peak(peak),
    .lives(lives)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic push(input int c, input bit cc, input logic [1:0] ph,
                      input logic [1:0] r, input logic [3:0] s,
                      input bit cp, input logic [11:0] pk,
                      input logic [1:0] lv);
    ev_t e;
    e.cyc = c; e.chk_cyc = cc; e.ph = ph; e.res = r; e.secs = s;
    e.chk_peak = cp; e.peak = pk; e.lives = lv;
    sb.push_back(e);
  endtask

  initial begin
    logic [5:0] last;
    ev_t e;
    string t;
    last = 6'b000001;
    nev = 0;
    forever begin
      @(negedge clk);
      if ({phase, res, lives} != last) begin
        last = {phase, res, lives};
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event ph=%0d res=%0d lives=%0d required none",
                   phase, res, lives);
        end else begin
          e = sb.pop_front();
          t = $sformatf("ev%0d", nev);
          nev++;
          if (e.chk_cyc) chk({t, "_cycle"}, cyc, e.cyc);
          chk({t, "_phase"}, phase, e.ph);
          chk({t, "_res"}, res, e.res);
          chk({t, "_secs"}, secs_left, e.secs);
          if (e.chk_peak) chk({t, "_peak"}, peak, e.peak);
          chk({t, "_lives"}, lives, e.lives);
        end
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Start lands on a posedge k with k%10==1, so FREEZE entry F%10==1 too
  // and window decisions fall on F+100n.
  task automatic start_round(output int f);
    int k;
    @(negedge clk);
    while (cyc % 10 != 0) @(negedge clk);
    k = cyc + 1;
    f = k + 1000;
    push(k, 1, 2'd1, 2'd0, 4'd1, 0, 12'd0, LV);
    push(f, 1, 2'd2, 2'd0, 4'd3, 0, 12'd0, LV);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic mic_pulse(input int at);
    logic [11:0] base;
    base = mic_in;
    wait_until(at - 1);
    mic_in = 12'd2301;
    @(negedge clk);
    mic_in = base;
  endtask

  initial begin
    int f;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    mic_in = 12'd2000;
    repeat (3) @(negedge clk);
    chk("rst_phase", phase, 0);
    chk("rst_res", res, 0);
    chk("rst_secs", secs_left, 0);
    chk("rst_peak", peak, 0);
    chk("rst_lives", lives, 1);
    rst_n = 1'b1;

    start_round(f);
    push(f + 3000, 1, 2'd3, 2'd1, 4'd0, 1, 12'd2000, LV);
    wait_until(f + 3010);

    mic_in = 12'd2300;
    start_round(f);
    push(f + 3000, 1, 2'd3, 2'd1, 4'd0, 1, 12'd2300, LV);
    wait_until(f + 3010);
    mic_in = 12'd2000;

`ifndef FREEZE_LIVES_EN
    start_round(f);
    push(f + 200, 1, 2'd3, 2'd2, 4'd3, 1, 12'd2301, 2'd1);
    mic_pulse(f + 109);
    wait_until(f + 210);

    start_round(f);
    push(f + 3000, 1, 2'd3, 2'd2, 4'd1, 1, 12'd2301, 2'd1);
    mic_pulse(f + 2959);
    wait_until(f + 3010);
`else
    start_round(f);
    push(f + 200, 1, 2'd2, 2'd0, 4'd3, 1, 12'd2301, 2'd2);
    push(f + 400, 1, 2'd2, 2'd0, 4'd3, 1, 12'd2301, 2'd1);
    push(f + 3000, 1, 2'd3, 2'd1, 4'd0, 1, 12'd2000, 2'd1);
    mic_pulse(f + 109);
    mic_pulse(f + 309);
    wait_until(f + 3010);

    start_round(f);
    push(f + 200, 1, 2'd2, 2'd0, 4'd3, 1, 12'd2301, 2'd2);
    push(f + 400, 1, 2'd2, 2'd0, 4'd3, 1, 12'd2301, 2'd1);
    push(f + 600, 1, 2'd3, 2'd2, 4'd3, 1, 12'd2301, 2'd0);
    mic_pulse(f + 109);
    mic_pulse(f + 309);
    mic_pulse(f + 509);
    wait_until(f + 610);
`endif

    start_round(f);
    wait_until(f + 500);
    chk("pre_rst_peak", peak, 2000);
    push(0, 0, 2'd0, 2'd0, 4'd0, 1, 12'd0, 2'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_phase", phase, 0);
    chk("async_res", res, 0);
    chk("async_peak", peak, 0);
    chk("async_secs", secs_left, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("queue_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
